ctrl_req_initiator: RTL and testbench

Host-side initiator for the class control endpoint. It takes a request description (bmRequestType, bRequest, wValue, wIndex, wLength) and packs it into the 64-bit setup word. It then drives the endpoint's enable/busy handshake, captures the returned parameter block from the 16/32/64-bit response buses, and reports the result with a one-cycle valid. It sits between the request scheduler and the control endpoint, in the opposite direction to the endpoint.

---
 rtl/ctrl_req_initiator_if.sv | 36 +++
 rtl/ctrl_req_initiator.sv | 139 +++++++++++++
 tb/tb_ctrl_req_initiator.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_req_initiator_if.sv
// ctrl_req_initiator_if: bundles the request-side and endpoint-side signals of the
// class control request initiator.
//   Request side : start, bmRequestType, bRequest, wValue, wIndex, wLength -> initiator;
//                  ready, resp_data, resp_valid, error <- initiator.
//   Endpoint side: data, enable <- initiator; busy, data_in16/32/64 -> initiator.
// modport master is taken by the initiator, modport slave by whatever drives it.
interface ctrl_req_initiator_if;
  logic        start;
  logic [7:0]  bmRequestType;
  logic [7:0]  bRequest;
  logic [15:0] wValue;
  logic [15:0] wIndex;
  logic [15:0] wLength;
  logic        ready;
  logic [63:0] data;
  logic        enable;
  logic        busy;
  logic [15:0] data_in16;
  logic [31:0] data_in32;
  logic [63:0] data_in64;
  logic [63:0] resp_data;
  logic        resp_valid;
  logic        error;

  modport master (
    input  start, bmRequestType, bRequest, wValue, wIndex, wLength,
    input  busy, data_in16, data_in32, data_in64,
    output ready, data, enable, resp_data, resp_valid, error
  );

  modport slave (
    output start, bmRequestType, bRequest, wValue, wIndex, wLength,
    output busy, data_in16, data_in32, data_in64,
    input  ready, data, enable, resp_data, resp_valid, error
  );
endinterface

// File: rtl/ctrl_req_initiator.sv
// ctrl_req_initiator: host-side initiator for the class control endpoint.
// Packs a request into the 64-bit setup word, runs the enable/busy handshake with
// the endpoint, captures the width-selected response and reports it with a
// one-cycle resp_valid (error qualified by resp_valid).
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - ctrl_req_initiator_if.master (request fields, handshake, response buses)
// Parameters:
//   TIMEOUT - max cycles spent in each handshake phase before aborting with error
//   CNT_W   - timeout counter width, 2**CNT_W > TIMEOUT
module ctrl_req_initiator #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input logic                   clk,
  input logic                   rst,
  ctrl_req_initiator_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StCapture,
    StFinish
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             enable_q;
  logic [63:0]      data_q;
  logic [63:0]      resp_data_q;
  logic             resp_valid_q;
  logic             error_q;

  logic [63:0]      cap_data;
  logic             cap_err;

  // Response selection works off the latched setup word, so the request fields
  // need no separate copy: data_q[63] is the direction bit, data_q[15:0] wLength.
  always_comb begin
    cap_data = '0;
    cap_err  = 1'b0;
    if (data_q[63]) begin
      case (data_q[15:0])
        16'd0:   cap_data = '0;
        16'd1:   cap_data = {56'd0, bus.data_in16[7:0]};
        16'd2:   cap_data = {48'd0, bus.data_in16};
        16'd4:   cap_data = {32'd0, bus.data_in32};
        16'd8:   cap_data = bus.data_in64;
        default: cap_err  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      enable_q     <= 1'b0;
      data_q       <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            data_q      <= {bus.bmRequestType, bus.bRequest, bus.wValue, bus.wIndex,
                            bus.wLength};
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            enable_q    <= 1'b1;
            error_q     <= 1'b0;
            resp_data_q <= '0;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          // busy already high on entry is taken as the acknowledge
          if (bus.busy) begin
            enable_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= StWaitDone;
          end else if (cnt_q == CntLast) begin
            enable_q     <= 1'b0;
            error_q      <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= StFinish;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (!bus.busy) begin
            state_q <= StCapture;
          end else if (cnt_q == CntLast) begin
            error_q      <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= StFinish;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StCapture: begin
          resp_data_q  <= cap_data;
          error_q      <= cap_err;
          resp_valid_q <= 1'b1;
          state_q      <= StFinish;
        end
        StFinish: begin
          // start seen here is deliberately not accepted; ready rises next cycle
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          ready_q  <= 1'b1;
          enable_q <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.enable     = enable_q;
  assign bus.data       = data_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_ctrl_req_initiator.sv
// tb_ctrl_req_initiator: directed self-checking bench for ctrl_req_initiator.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ctrl_req_initiator;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  ctrl_req_initiator_if bus ();

  ctrl_req_initiator #(
    .TIMEOUT (64),
    .CNT_W   (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One request with a scripted endpoint: busy is high for cycles
  // [bdly, bdly+blen) counted from the first ISSUE cycle.
  task automatic run_req(input string tag, input logic [7:0] rt, input logic [7:0] rq,
                         input logic [15:0] wv, input logic [15:0] wi, input logic [15:0] wl,
                         input int bdly, input int blen, input logic [15:0] d16,
                         input logic [31:0] d32, input logic [63:0] d64,
                         input logic [63:0] exp_resp, input logic exp_err,
                         input int exp_lat, input int exp_en);
    int k;
    int en_cnt;
    bit done;
    @(negedge clk);
    bus.bmRequestType = rt;
    bus.bRequest      = rq;
    bus.wValue        = wv;
    bus.wIndex        = wi;
    bus.wLength       = wl;
    bus.data_in16     = d16;
    bus.data_in32     = d32;
    bus.data_in64     = d64;
    bus.busy          = 1'b0;
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq({tag, "_setup"}, bus.data, {rt, rq, wv, wi, wl});
    check_eq({tag, "_ready_low"}, 64'(bus.ready), 64'd0);
    k = 0;
    en_cnt = 0;
    done = 1'b0;
    while (!done && k < 300) begin
      if (bus.resp_valid) begin
        done = 1'b1;
      end else begin
        en_cnt += int'(bus.enable);
        bus.busy = (k >= bdly) && (k < bdly + blen);
        @(negedge clk);
        k++;
      end
    end
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_latency"}, 64'(k), 64'(exp_lat));
    check_eq({tag, "_enable_cycles"}, 64'(en_cnt), 64'(exp_en));
    check_eq({tag, "_resp_data"}, bus.resp_data, exp_resp);
    check_eq({tag, "_error"}, 64'(bus.error), 64'(exp_err));
    check_eq({tag, "_enable_off"}, 64'(bus.enable), 64'd0);
    bus.busy = 1'b0;
    @(negedge clk);
    check_eq({tag, "_valid_pulse"}, 64'(bus.resp_valid), 64'd0);
    check_eq({tag, "_ready_back"}, 64'(bus.ready), 64'd1);
    check_eq({tag, "_resp_hold"}, bus.resp_data, exp_resp);
  endtask

  initial begin
    int rv_cnt;
    int p0;
    int p1;
    int rec_ready[20];
    int rec_en[20];

    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    bus.start         = 1'b0;
    bus.bmRequestType = '0;
    bus.bRequest      = '0;
    bus.wValue        = '0;
    bus.wIndex        = '0;
    bus.wLength       = '0;
    bus.busy          = 1'b0;
    bus.data_in16     = '0;
    bus.data_in32     = '0;
    bus.data_in64     = '0;

    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", 64'(bus.ready), 64'd1);
    check_eq("rst_enable", 64'(bus.enable), 64'd0);
    check_eq("rst_data", bus.data, 64'd0);
    check_eq("rst_resp_data", bus.resp_data, 64'd0);
    check_eq("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check_eq("rst_error", 64'(bus.error), 64'd0);
    rst = 1'b0;

    // GET_INFO, busy high for 3 cycles
    run_req("get_info", 8'hA1, 8'h87, 16'h0000, 16'h0000, 16'd2, 0, 3, 16'h0003, 32'h0,
            64'h0, 64'h3, 1'b0, 5, 1);
    check_eq("get_info_setup_const", bus.data, 64'hA187_0000_0000_0002);
    // minimum latency, 64-bit response
    run_req("len8", 8'hA1, 8'h87, 16'h1234, 16'h0001, 16'd8, 0, 1, 16'hFFFF, 32'hFFFF_FFFF,
            64'h0000_0000_0000_000C, 64'hC, 1'b0, 3, 1);
    // late acknowledge, 32-bit response
    run_req("len4", 8'hA1, 8'h01, 16'h0000, 16'h0002, 16'd4, 2, 1, 16'hFFFF, 32'h1,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 5, 3);
    run_req("len1", 8'hC0, 8'h05, 16'h0000, 16'h0000, 16'd1, 0, 1, 16'hABCD, 32'h0,
            64'h0, 64'hCD, 1'b0, 3, 1);
    run_req("len3_bad", 8'hA1, 8'h87, 16'h0000, 16'h0000, 16'd3, 0, 1, 16'h1111, 32'h2222,
            64'h3333, 64'h0, 1'b1, 3, 1);
    run_req("h2d", 8'h21, 8'h09, 16'h0000, 16'h0000, 16'd2, 0, 1, 16'h5555, 32'h0,
            64'h0, 64'h0, 1'b0, 3, 1);
    run_req("len0", 8'hA1, 8'h87, 16'h0000, 16'h0000, 16'd0, 0, 1, 16'h5555, 32'h6666,
            64'h7777, 64'h0, 1'b0, 3, 1);
    // endpoint never acknowledges
    run_req("to_issue", 8'hA1, 8'h87, 16'h0000, 16'h0000, 16'd2, 1000, 0, 16'h0003, 32'h0,
            64'h0, 64'h0, 1'b1, 64, 64);
    // endpoint never releases busy
    run_req("to_wait", 8'hA1, 8'h87, 16'h0000, 16'h0000, 16'd2, 0, 1000, 16'h0003, 32'h0,
            64'h0, 64'h0, 1'b1, 65, 1);

    // reset while in WAIT_DONE
    @(negedge clk);
    bus.bmRequestType = 8'hA1;
    bus.bRequest      = 8'h87;
    bus.wLength       = 16'd2;
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.busy  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_enable", 64'(bus.enable), 64'd0);
    check_eq("rst_mid_ready", 64'(bus.ready), 64'd1);
    check_eq("rst_mid_data", bus.data, 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    bus.busy = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      rv_cnt += int'(bus.resp_valid);
      @(negedge clk);
    end
    check_eq("rst_mid_no_valid", 64'(rv_cnt), 64'd0);
    run_req("after_rst", 8'hA1, 8'h87, 16'h0000, 16'h0000, 16'd2, 0, 2, 16'h0042, 32'h0,
            64'h0, 64'h42, 1'b0, 4, 1);

    // back-to-back with start held high; endpoint acknowledges enable immediately
    @(negedge clk);
    bus.data_in16 = 16'h0007;
    bus.wLength   = 16'd2;
    bus.start     = 1'b1;
    p0 = -1;
    p1 = -1;
    rv_cnt = 0;
    for (int t = 0; t < 20; t++) begin
      rec_ready[t] = int'(bus.ready);
      rec_en[t]    = int'(bus.enable);
      if (bus.resp_valid) begin
        if (rv_cnt == 0) p0 = t;
        else if (rv_cnt == 1) p1 = t;
        rv_cnt++;
      end
      if (t == 11) bus.start = 1'b0;
      bus.busy = bus.enable;
      @(negedge clk);
    end
    bus.busy = 1'b0;
    check_eq("b2b_first_valid", 64'(p0), 64'd4);
    check_eq("b2b_gap", 64'(p1 - p0), 64'd5);
    check_eq("b2b_pulses", 64'(rv_cnt), 64'd3);
    if (p0 >= 0 && p0 + 2 < 20) begin
      check_eq("b2b_ready_after_finish", 64'(rec_ready[p0 + 1]), 64'd1);
      check_eq("b2b_second_issue", 64'(rec_en[p0 + 2]), 64'd1);
    end else begin
      check_eq("b2b_first_valid_range", 64'(p0), 64'd4);
    end
    check_eq("b2b_resp_data", bus.resp_data, 64'h7);
    check_eq("b2b_idle", 64'(bus.ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
